// File: rtl/sram_access_sequencer.sv
// Turns parallel set-address / write / read commands into the serial address
// stream, counter-increment pulse and SRAM strobes used by the load path.
module sram_access_sequencer #(
  parameter int ADDR_WIDTH    = 21,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic                  cmd_inc,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_wdata,
  output logic                  rsp_valid,
  output logic [7:0]            rsp_rdata,
  output logic [ADDR_WIDTH-1:0] cur_addr,
  output logic                  sreg_si,
  output logic                  sreg_clk,
  output logic                  sreg_en_n,
  output logic                  counter_n,
  output logic                  we_n,
  output logic                  oe_n,
  output logic [7:0]            data_out,
  output logic                  data_oe,
  input  logic [7:0]            data_in,
  output logic [2:0]            dbg_state
);

  // Command handshake: a command is taken on a rising edge where
  // cmd_valid && cmd_ready; cmd_ready is high only while idle and one
  // rsp_valid pulse follows every accepted command that is not reset away.

  typedef enum logic [2:0] {IDLE, SHIFT, SETUP, STROBE, HOLD, INC, DONE} state_t;

  localparam logic [1:0] OP_SET   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  localparam int CW = $clog2(2*ADDR_WIDTH + SETUP_CYCLES + STROBE_CYCLES + 1);
  localparam logic [CW-1:0] SHIFT_LAST  = CW'(2*ADDR_WIDTH - 1);
  localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYCLES - 1);

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [1:0]            op_q;
  logic                  inc_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] sh;

  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= '0;
      inc_q     <= 1'b0;
      addr_q    <= '0;
      sh        <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      cur_addr  <= '0;
      sreg_si   <= 1'b0;
      sreg_clk  <= 1'b0;
      sreg_en_n <= 1'b1;
      counter_n <= 1'b1;
      we_n      <= 1'b1;
      oe_n      <= 1'b1;
      data_out  <= '0;
      data_oe   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            inc_q     <= cmd_inc;
            addr_q    <= cmd_addr;
            cnt       <= '0;
            cmd_ready <= 1'b0;
            case (cmd_op)
              OP_SET: begin
                state     <= SHIFT;
                sh        <= cmd_addr;
                sreg_si   <= cmd_addr[ADDR_WIDTH-1];
                sreg_clk  <= 1'b0;
                sreg_en_n <= 1'b0;
              end
              OP_WRITE: begin
                state    <= SETUP;
                data_out <= cmd_wdata;
                data_oe  <= 1'b1;
              end
              OP_READ: begin
                state <= STROBE;
                oe_n  <= 1'b0;
              end
              default: begin
                state     <= DONE;
                rsp_valid <= 1'b1;
              end
            endcase
          end
        end
        // Even cnt values are the low phase of a bit, odd values the high phase.
        SHIFT: begin
          if (cnt == SHIFT_LAST) begin
            state     <= DONE;
            cur_addr  <= addr_q;
            sreg_en_n <= 1'b1;
            sreg_clk  <= 1'b0;
            sreg_si   <= 1'b0;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
            if (!cnt[0]) begin
              sreg_clk <= 1'b1;
            end else begin
              sreg_clk <= 1'b0;
              sreg_si  <= sh[ADDR_WIDTH-2];
              sh       <= {sh[ADDR_WIDTH-2:0], 1'b0};
            end
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            state <= STROBE;
            cnt   <= '0;
            we_n  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STROBE: begin
          if (cnt == STROBE_LAST) begin
            we_n <= 1'b1;
            oe_n <= 1'b1;
            if (op_q == OP_READ) begin
              rsp_rdata <= data_in;
            end
            if (op_q == OP_WRITE) begin
              state <= HOLD;
            end else if (inc_q) begin
              state     <= INC;
              counter_n <= 1'b0;
            end else begin
              state     <= DONE;
              rsp_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HOLD: begin
          data_oe <= 1'b0;
          if (inc_q) begin
            state     <= INC;
            counter_n <= 1'b0;
          end else begin
            state     <= DONE;
            rsp_valid <= 1'b1;
          end
        end
        INC: begin
          state     <= DONE;
          counter_n <= 1'b1;
          cur_addr  <= cur_addr + ADDR_WIDTH'(1);
          rsp_valid <= 1'b1;
        end
        DONE: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_sequencer.sv
// Bench for sram_access_sequencer: a waveform-table model built per accepted
// command is compared against every output on every falling edge.
module tb_sram_access_sequencer;

  localparam int AW = 21;
  localparam int SU = 1;
  localparam int ST = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b11;
  logic          cmd_inc = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [7:0]    cmd_wdata = '0;
  logic          rsp_valid;
  logic [7:0]    rsp_rdata;
  logic [AW-1:0] cur_addr;
  logic          sreg_si, sreg_clk, sreg_en_n, counter_n, we_n, oe_n, data_oe;
  logic [7:0]    data_out;
  logic [7:0]    data_in = '0;
  logic [2:0]    dbg_state;

  sram_access_sequencer #(.ADDR_WIDTH(AW), .SETUP_CYCLES(SU), .STROBE_CYCLES(ST)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_inc(cmd_inc), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .cur_addr(cur_addr),
    .sreg_si(sreg_si), .sreg_clk(sreg_clk), .sreg_en_n(sreg_en_n),
    .counter_n(counter_n), .we_n(we_n), .oe_n(oe_n), .data_out(data_out),
    .data_oe(data_oe), .data_in(data_in), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: one expected output vector per cycle after an accept
  typedef struct packed {
    logic          rdy;
    logic          rsp;
    logic [7:0]    rdata;
    logic [AW-1:0] addr;
    logic          si, sclk, en_n, cnt_n, we_n, oe_n, doe;
    logic [7:0]    dout;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          cur_exp;
  logic [AW-1:0] m_addr  = '0;
  logic [7:0]    m_rdata = '0;

  function automatic exp_t base_e(input bit busy);
    exp_t e;
    e.rdy = !busy; e.rsp = 1'b0; e.rdata = m_rdata; e.addr = m_addr;
    e.si = 1'b0; e.sclk = 1'b0; e.en_n = 1'b1; e.cnt_n = 1'b1;
    e.we_n = 1'b1; e.oe_n = 1'b1; e.doe = 1'b0; e.dout = '0;
    return e;
  endfunction

  function automatic void model_flush();
    exp_q.delete();
    m_addr  = '0;
    m_rdata = '0;
  endfunction

  function automatic void push_inc();
    exp_t e;
    e = base_e(1); e.cnt_n = 1'b0; exp_q.push_back(e);
    m_addr = m_addr + AW'(1);
  endfunction

  function automatic void model_push(input logic [1:0] op, input logic inc,
                                     input logic [AW-1:0] a, input logic [7:0] wd,
                                     input logic [7:0] din);
    exp_t e;
    case (op)
      2'b00: begin
        for (int i = 0; i < AW; i++) begin
          e = base_e(1); e.en_n = 1'b0; e.si = a[AW-1-i];
          exp_q.push_back(e);
          e.sclk = 1'b1;
          exp_q.push_back(e);
        end
        m_addr = a;
      end
      2'b01: begin
        e = base_e(1); e.doe = 1'b1; e.dout = wd;
        for (int i = 0; i < SU; i++) exp_q.push_back(e);
        e.we_n = 1'b0;
        for (int i = 0; i < ST; i++) exp_q.push_back(e);
        e.we_n = 1'b1;
        exp_q.push_back(e);
        if (inc) push_inc();
      end
      2'b10: begin
        e = base_e(1); e.oe_n = 1'b0;
        for (int i = 0; i < ST; i++) exp_q.push_back(e);
        m_rdata = din;
        if (inc) push_inc();
      end
      default: ;
    endcase
    e = base_e(1); e.rsp = 1'b1;
    exp_q.push_back(e);
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic inc);
    case (op)
      2'b00:   return 2*AW + 1;
      2'b01:   return SU + ST + 1 + (inc ? 1 : 0) + 1;
      2'b10:   return ST + (inc ? 1 : 0) + 1;
      default: return 1;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!reset && cmd_valid && cur_exp.rdy)
      model_push(cmd_op, cmd_inc, cmd_addr, cmd_wdata, data_in);
  end

  // Scoreboard compare on every falling edge
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = base_e(0);
    cur_exp = e;
    chk("cmd_ready", cmd_ready, e.rdy);
    chk("rsp_valid", rsp_valid, e.rsp);
    chk("rsp_rdata", rsp_rdata, e.rdata);
    chk("cur_addr", cur_addr, e.addr);
    chk("sreg_clk", sreg_clk, e.sclk);
    chk("sreg_en_n", sreg_en_n, e.en_n);
    chk("counter_n", counter_n, e.cnt_n);
    chk("we_n", we_n, e.we_n);
    chk("oe_n", oe_n, e.oe_n);
    chk("data_oe", data_oe, e.doe);
    if (!e.en_n) chk("sreg_si", sreg_si, e.si);
    if (e.doe) chk("data_out", data_out, e.dout);
  end

  // Per-command statistics for the directed literal checks
  int          st_cyc, st_en, st_we, st_oe, st_cnt, st_rsp, st_nbits, st_doe_first, st_we_first;
  logic [AW-1:0] st_bits;

  task automatic clear_stats();
    st_cyc = 1; st_en = 0; st_we = 0; st_oe = 0; st_cnt = 0; st_rsp = 0;
    st_nbits = 0; st_doe_first = 0; st_we_first = 0; st_bits = '0;
  endtask

  always @(negedge clk) begin
    if (!sreg_en_n) st_en++;
    if (!we_n) st_we++;
    if (!oe_n) st_oe++;
    if (!counter_n) st_cnt++;
    if (rsp_valid) st_rsp++;
    if (sreg_clk) begin
      st_bits = {st_bits[AW-2:0], sreg_si};
      st_nbits++;
    end
    if (data_oe && st_doe_first == 0) st_doe_first = st_cyc;
    if (!we_n && st_we_first == 0) st_we_first = st_cyc;
    st_cyc++;
  end

  // Driver: issue one command; optionally reset at cycle abort_at after accept
  task automatic issue(input logic [1:0] op, input logic inc, input logic [AW-1:0] a,
                       input logic [7:0] wd, input logic [7:0] din, input int abort_at,
                       input bit hold_valid, output int lat);
    @(posedge clk); #2;
    cmd_valid = 1'b1; cmd_op = op; cmd_inc = inc; cmd_addr = a; cmd_wdata = wd; data_in = din;
    @(posedge clk); #1;
    clear_stats();
    #1;
    if (!hold_valid) cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_addr = AW'($urandom); cmd_wdata = 8'($urandom); cmd_inc = 1'($urandom);
    lat = 0;
    if (abort_at > 0) begin
      repeat (abort_at - 1) @(posedge clk);
      #2;
      reset = 1'b1;
      model_flush();
      #1;
      chk("rst_we_n", we_n, 1'b1);
      chk("rst_oe_n", oe_n, 1'b1);
      chk("rst_sreg_en_n", sreg_en_n, 1'b1);
      chk("rst_counter_n", counter_n, 1'b1);
      chk("rst_data_oe", data_oe, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      cmd_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
    end else begin
      for (int k = 0; k < 200; k++) begin
        @(negedge clk); #1;
        if (rsp_valid) begin
          lat = k + 1;
          break;
        end
        if (hold_valid) begin
          cmd_op   = cmd_op + 2'd1;
          cmd_addr = AW'($urandom);
        end
      end
      if (lat == 0) chk("rsp_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    #1 reset = 1'b1;
    model_flush();
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk); #1;
    chk("reset_cmd_ready", cmd_ready, 1'b1);
    chk("reset_rsp_rdata", rsp_rdata, 8'h00);
    chk("reset_cur_addr", cur_addr, '0);
    chk("reset_sreg_si", sreg_si, 1'b0);
    chk("reset_sreg_clk", sreg_clk, 1'b0);
    chk("reset_data_out", data_out, 8'h00);

    issue(2'b00, 1'b0, 21'h15A5A3, 8'h00, 8'h00, 0, 1'b0, lat);
    chk("set_latency", lat, 43);
    chk("set_en_low_cycles", st_en, 42);
    chk("set_nbits", st_nbits, 21);
    chk("set_serial_bits", st_bits, 21'h15A5A3);
    chk("set_cur_addr", cur_addr, 21'h15A5A3);

    issue(2'b01, 1'b0, '0, 8'h3C, 8'h00, 0, 1'b0, lat);
    chk("wr_latency", lat, 5);
    chk("wr_we_low_cycles", st_we, 2);
    chk("wr_doe_first", st_doe_first, 1);
    chk("wr_we_first", st_we_first, 2);
    chk("wr_counter_pulses", st_cnt, 0);

    issue(2'b10, 1'b1, '0, 8'h00, 8'hA7, 0, 1'b0, lat);
    chk("rd_latency", lat, 4);
    chk("rd_oe_low_cycles", st_oe, 2);
    chk("rd_counter_pulses", st_cnt, 1);
    chk("rd_rdata", rsp_rdata, 8'hA7);
    chk("rd_cur_addr", cur_addr, 21'h15A5A4);

    issue(2'b00, 1'b0, 21'h1FFFFF, 8'h00, 8'h00, 0, 1'b0, lat);
    issue(2'b01, 1'b1, '0, 8'h5A, 8'h00, 0, 1'b0, lat);
    chk("wrap_latency", lat, 6);
    chk("wrap_cur_addr", cur_addr, '0);
    chk("wrap_counter_pulses", st_cnt, 1);

    issue(2'b11, 1'b0, '0, 8'h00, 8'h00, 0, 1'b0, lat);
    chk("nop_latency", lat, 1);

    issue(2'b00, 1'b0, 21'h0F0F0F, 8'h00, 8'h00, 0, 1'b1, lat);
    chk("busy_latency", lat, 43);
    chk("busy_rsp_count", st_rsp, 1);
    chk("busy_cur_addr", cur_addr, 21'h0F0F0F);

    issue(2'b00, 1'b0, 21'h12345, 8'h00, 8'h00, 21, 1'b0, lat);
    @(negedge clk); #1;
    chk("abort_shift_ready", cmd_ready, 1'b1);
    issue(2'b01, 1'b0, '0, 8'h99, 8'h00, 3, 1'b0, lat);
    @(negedge clk); #1;
    chk("abort_write_ready", cmd_ready, 1'b1);
    issue(2'b00, 1'b0, 21'h0ABCDE, 8'h00, 8'h00, 0, 1'b0, lat);
    chk("post_abort_latency", lat, 43);
    chk("post_abort_cur_addr", cur_addr, 21'h0ABCDE);

    for (int n = 0; n < 60; n++) begin
      logic [1:0]    op;
      logic          inc;
      logic [AW-1:0] a;
      int            abort;
      op    = 2'($urandom_range(0, 3));
      inc   = 1'($urandom_range(0, 1));
      a     = ($urandom_range(0, 3) == 0) ? 21'h1FFFFF : AW'($urandom);
      abort = ($urandom_range(0, 9) == 0) ? $urandom_range(1, exp_lat(op, inc)) : 0;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      issue(op, inc, a, 8'($urandom), 8'($urandom), abort, 1'($urandom_range(0, 1)), lat);
      if (abort == 0) chk("rand_latency", lat, exp_lat(op, inc));
    end

    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_access_sequencer.md
Name: sram_access_sequencer

Overview:
- Upstream command stage for the SRAM load path: turns parallel AVR-side commands (set address, write byte, read byte) into the serial-address and strobe signalling consumed by the address shift register and bus stage.
- Shifts a 21-bit address MSB-first, drives the counter-increment pulse, and times the we_n/oe_n strobes with setup and hold.
- Single ready/valid command interface in; one response pulse out per completed command.

Parameters:
- ADDR_WIDTH, 21, SRAM address width; shift length and shadow counter width.
- SETUP_CYCLES, 1, cycles data is driven before we_n falls; minimum 1.
- STROBE_CYCLES, 2, cycles we_n or oe_n is held low; minimum 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  high only in IDLE; a command is accepted on an edge where cmd_valid && cmd_ready.
- cmd_op  input  2  00 SET_ADDR, 01 WRITE, 10 READ, 11 NOP.
- cmd_inc  input  1  for WRITE/READ: increment the address after the access.
- cmd_addr  input  ADDR_WIDTH  address for SET_ADDR.
- cmd_wdata  input  8  byte for WRITE.
- rsp_valid  output  1  one-cycle pulse when a command completes.
- rsp_rdata  output  8  byte captured by READ; holds its value until the next READ.
- cur_addr  output  ADDR_WIDTH  shadow copy of the shift-register address.
- sreg_si  output  1  serial address bit.
- sreg_clk  output  1  shift clock: one high cycle per bit.
- sreg_en_n  output  1  low for the whole shift window.
- counter_n  output  1  one-cycle low pulse that increments the external address.
- we_n  output  1  SRAM write strobe.
- oe_n  output  1  SRAM read strobe.
- data_out  output  8  write data.
- data_oe  output  1  drive enable for data_out.
- data_in  input  8  read data from the bus stage.

Behaviour:
- Reset values:
  - cmd_ready=1, rsp_valid=0, rsp_rdata=0, cur_addr=0.
  - sreg_si=0, sreg_clk=0, sreg_en_n=1, counter_n=1.
  - we_n=1, oe_n=1, data_out=0, data_oe=0.
  - FSM in IDLE.
- Reset mid-operation: all strobes go inactive immediately (asynchronous). The in-flight command is dropped and gets no response.
- States: IDLE, SHIFT, SETUP, STROBE, HOLD, INC, DONE.
- IDLE:
  - On accept: latch op, inc, addr and wdata.
  - SET_ADDR -> SHIFT; WRITE -> SETUP; READ -> STROBE; NOP -> DONE.
  - cmd_ready drops the cycle after accept.
- SHIFT:
  - Runs 2*ADDR_WIDTH cycles with sreg_en_n=0.
  - For bit i (MSB first): the low-phase cycle presents sreg_si=addr[ADDR_WIDTH-1-i] with sreg_clk=0. The next cycle holds sreg_si stable with sreg_clk=1.
  - After the last bit, cur_addr<=latched addr, sreg_en_n=1 -> DONE.
  - Total SET_ADDR latency from accept edge to rsp_valid is 2*ADDR_WIDTH+1 = 43 cycles.
- WRITE:
  - SETUP: data_oe=1, data_out=wdata for SETUP_CYCLES.
  - STROBE: we_n=0 for STROBE_CYCLES.
  - HOLD: 1 cycle with we_n=1 and data still driven.
  - Then INC if inc=1, else DONE. data_oe drops on leaving HOLD.
- READ:
  - STROBE: oe_n=0 for STROBE_CYCLES; rsp_rdata<=data_in on the last strobe cycle.
  - Then INC if inc=1, else DONE.
  - data_oe stays 0 throughout.
- INC:
  - counter_n=0 for exactly 1 cycle.
  - cur_addr<=cur_addr+1 modulo 2^ADDR_WIDTH, so 0x1FFFFF wraps to 0x000000.
  - Then DONE.
- DONE: rsp_valid=1 for 1 cycle, then IDLE with cmd_ready=1.
- Throughput: back-to-back commands are accepted no sooner than the cycle after DONE.
- cmd_valid while busy: ignored and not latched. Command inputs are don't-care outside accept edges.
- we_n and oe_n are never low simultaneously. sreg_en_n is never low while either strobe is low.
- Default-parameter latencies (accept edge to rsp_valid): WRITE 5 cycles, WRITE+inc 6, READ 3, READ+inc 4, NOP 1.

Test Plan:
- Reset, then SET_ADDR 0x15A5A3 -> sreg_si sampled on 21 sreg_clk highs reads 1_0101_1010_0101_1010_0011 MSB-first; sreg_en_n low 42 cycles; rsp_valid at cycle 43; cur_addr=0x15A5A3.
- WRITE 0x3C inc=0 -> data_oe high 1 cycle before we_n; we_n low exactly 2 cycles; data_out=0x3C through HOLD; counter_n stays 1; rsp_valid at cycle 5.
- READ inc=1 with data_in=0xA7 -> oe_n low 2 cycles; counter_n one-cycle low pulse after; rsp_rdata=0xA7; cur_addr +1; rsp_valid at cycle 4.
- SET_ADDR 0x1FFFFF then WRITE inc=1 -> cur_addr wraps to 0x000000; exactly one counter_n pulse.
- cmd_valid held high with alternating ops during a SHIFT -> no extra accepts; exactly one rsp_valid per accepted command; cmd_ready low while busy.
- Assert reset at shift bit 10 and during we_n low -> all strobes inactive in the same cycle, no rsp_valid, cmd_ready=1 after release; the next SET_ADDR completes normally.
